jt4701_quadgen: RTL
===================

Name: jt4701_quadgen

Overview:
- Upstream stage of the uPD4701A-equivalent trackball counter: turns signed mouse deltas (PS/2 or USB host, strobed) into the quadrature A/B pairs and active-low button lines that the counter consumes.
- One pending-step accumulator per axis, drained at a fixed step rate.
- Phase sequence chosen so the downstream counter increments for positive deltas.
- Lets games that read a 4701 trackball take a modern mouse.

Parameters:
- CNTW, 10, width of each signed pending accumulator; saturation limit ±(2^(CNTW-1)-1).
- DIV, 16, clocks per quadrature step tick (≥2).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- mouse_st  in  1  one-cycle strobe: dx/dy/btn valid.
- mouse_dx  in  8  signed X delta, two's complement.
- mouse_dy  in  8  signed Y delta, two's complement.
- mouse_btn  in  3  [0]=left, [1]=right, [2]=middle; 1=pressed.
- x_out  out  2  X quadrature, MSB=A, LSB=B.
- y_out  out  2  Y quadrature, MSB=A, LSB=B.
- leftn  out  1  left button, active-low.
- rightn  out  1  right button, active-low.
- middlen  out  1  middle button, active-low.
- busy  out  1  high while either accumulator is non-zero.

Behaviour:
- Reset (rstn=0, async):
  - x_out=y_out=2'b00; leftn=rightn=middlen=1; busy=0.
  - Accumulators=0; prescaler=DIV-1.
- Prescaler:
  - Down-counter, counts every clk.
  - tick=1 in the cycle it reads 0; reloads DIV-1 in that cycle.
  - Free-running, shared by both axes.
- Per-axis phase:
  - 2-bit registered state sequence 00→10→11→01→00 is "forward"; the reverse order is "backward".
  - Forward makes the downstream 4701 counter increase.
  - One accumulator unit = one phase transition.
- On tick, the step decision uses the accumulator value before this cycle's update:
  - >0: advance phase forward, accumulator −1.
  - <0: advance phase backward, accumulator +1.
  - =0: phase holds.
- On mouse_st:
  - dx (dy) is sign-extended to CNTW+1 bits and added.
  - Result saturates to ±(2^(CNTW-1)-1); no wrap.
- Same-cycle strobe and tick: new = sat(old + delta ∓ step), step direction taken from old.
- Latency:
  - Accumulator updates the cycle after mouse_st.
  - First step appears on x_out/y_out the cycle after the next tick.
  - Steps are then spaced exactly DIV clocks.
- Buttons:
  - Registered on mouse_st only, inverted: leftn=~btn[0], etc.
  - One-cycle latency; held between strobes.
- busy: registered OR of (accX≠0, accY≠0), updated every cycle.
- Axes are independent; both may step on the same tick.
- Reset mid-step: all state clears at once, phase returns to 00. The downstream counter then sees at most one spurious transition; that is accepted.

Optional Feature:
- Macro JT4701_QUADGEN_ACCEL_EN.
- Defined: when |accumulator| of either axis ≥ 2^(CNTW-2), the prescaler reloads DIV/2-1 instead of DIV-1. This doubles the step rate to drain large moves.
- The threshold is evaluated at reload time.
- Undefined: reload is always DIV-1; step rate is fixed.

Test Plan:
- rstn low mid-activity with dx pending → within the same cycle x_out=00, busy=0, leftn/rightn/middlen=1; no further steps after release.
- DIV=4, dx=+3 strobe → x_out 00→10→11→01 at 4-clk intervals, then stable; busy drops after third step; y_out stays 00.
- Follow-up dx=−2 → x_out 01→11→10; downstream jt4701 count returns to its prior value minus the reverse steps.
- DIV=256, five dx=+127 strobes on consecutive cycles → accumulator clamps at 511, no wrap; X then steps forward continuously.
- Accumulator=+1, strobe dx=−1 coinciding with tick → forward step this tick, accumulator=−1, one backward step on next tick, then idle.
- mouse_btn=3'b101 strobe → next cycle leftn=0, rightn=1, middlen=0. With JT4701_QUADGEN_ACCEL_EN, DIV=8, dx=+127 (≥256 pending after preload) → step spacing 4 clk until below 256, then 8.

Source files
------------

// File: rtl/jt4701_quadgen_if.sv
// Mouse report bundle feeding jt4701_quadgen: one-cycle strobe plus
// signed X/Y deltas and the button state captured with it.
interface jt4701_quadgen_if;
  logic       mouse_st;
  logic [7:0] mouse_dx;
  logic [7:0] mouse_dy;
  logic [2:0] mouse_btn;

  modport master (output mouse_st, mouse_dx, mouse_dy, mouse_btn);
  modport slave  (input  mouse_st, mouse_dx, mouse_dy, mouse_btn);
endinterface

// File: rtl/jt4701_quadgen.sv
// jt4701_quadgen: converts strobed signed mouse deltas into quadrature A/B
// pairs and active-low buttons for a uPD4701A-style trackball counter.
// Each axis keeps a saturating pending-step accumulator, drained one phase
// transition per prescaler tick.
// Optional: define JT4701_QUADGEN_ACCEL_EN to halve the tick period while
// either accumulator magnitude is at least 2^(CNTW-2).
// CNTW must be at least 8 so an 8-bit delta fits the extended sum.
module jt4701_quadgen #(
  parameter int CNTW = 10,
  parameter int DIV  = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  jt4701_quadgen_if.slave      mouse,
  output logic [1:0]           x_out,
  output logic [1:0]           y_out,
  output logic                 leftn,
  output logic                 rightn,
  output logic                 middlen,
  output logic                 busy
);

  localparam int PW = $clog2(DIV);
  localparam logic signed [CNTW:0]   POS_LIM = $signed((CNTW+1)'((1 << (CNTW-1)) - 1));
  localparam logic signed [CNTW:0]   NEG_LIM = -POS_LIM;

  // Phase codes double as the A/B output pair; forward order is
  // 00 -> 10 -> 11 -> 01 -> 00.
  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_10 = 2'b10,
    PH_11 = 2'b11,
    PH_01 = 2'b01
  } phase_t;

  phase_t                  x_ph, x_ph_nx, y_ph, y_ph_nx;
  logic signed [CNTW-1:0]  acc_x, acc_y, acc_x_nx, acc_y_nx;
  logic [PW-1:0]           pre, reload;
  logic                    tick;

  function automatic phase_t ph_step(input phase_t ph, input logic fwd);
    phase_t r;
    r = PH_00;
    case (ph)
      PH_00:   r = fwd ? PH_10 : PH_01;
      PH_10:   r = fwd ? PH_11 : PH_00;
      PH_11:   r = fwd ? PH_01 : PH_10;
      PH_01:   r = fwd ? PH_00 : PH_11;
      default: r = PH_00;
    endcase
    return r;
  endfunction

  // Step direction comes from the old value; the strobe delta and the step
  // are combined before a single saturation so nothing ever wraps.
  function automatic logic signed [CNTW-1:0] acc_next(
    input logic signed [CNTW-1:0] old,
    input logic                   st,
    input logic [7:0]             d,
    input logic                   tk
  );
    logic signed [CNTW:0] sum;
    sum = {old[CNTW-1], old};
    if (st)
      sum = sum + {{(CNTW-7){d[7]}}, d};
    if (tk && (old > 0))
      sum = sum - (CNTW+1)'(1);
    else if (tk && (old < 0))
      sum = sum + (CNTW+1)'(1);
    if (sum > POS_LIM)
      return POS_LIM[CNTW-1:0];
    else if (sum < NEG_LIM)
      return NEG_LIM[CNTW-1:0];
    return sum[CNTW-1:0];
  endfunction

  assign tick = (pre == '0);

`ifdef JT4701_QUADGEN_ACCEL_EN
  localparam logic signed [CNTW-1:0] ACC_TH  = $signed(CNTW'(1 << (CNTW-2)));
  localparam logic signed [CNTW-1:0] ACC_NTH = -ACC_TH;
  logic big;
  assign big    = (acc_x >= ACC_TH) || (acc_x <= ACC_NTH) ||
                  (acc_y >= ACC_TH) || (acc_y <= ACC_NTH);
  assign reload = big ? PW'(DIV/2 - 1) : PW'(DIV - 1);
`else
  assign reload = PW'(DIV - 1);
`endif

  // Free-running step-rate prescaler shared by both axes.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)     pre <= PW'(DIV - 1);
    else if (tick) pre <= reload;
    else           pre <= pre - 1'b1;
  end

  // Next accumulator values and next phases for both axes.
  always_comb begin
    acc_x_nx = acc_next(acc_x, mouse.mouse_st, mouse.mouse_dx, tick);
    acc_y_nx = acc_next(acc_y, mouse.mouse_st, mouse.mouse_dy, tick);
    x_ph_nx  = x_ph;
    y_ph_nx  = y_ph;
    if (tick && (acc_x != '0)) x_ph_nx = ph_step(x_ph, acc_x > 0);
    if (tick && (acc_y != '0)) y_ph_nx = ph_step(y_ph, acc_y > 0);
  end

  // Phase state and accumulator registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      x_ph  <= PH_00;
      y_ph  <= PH_00;
      acc_x <= '0;
      acc_y <= '0;
    end else begin
      x_ph  <= x_ph_nx;
      y_ph  <= y_ph_nx;
      acc_x <= acc_x_nx;
      acc_y <= acc_y_nx;
    end
  end

  // Buttons are captured inverted on each strobe and held in between.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      {middlen, rightn, leftn} <= '1;
    else if (mouse.mouse_st)
      {middlen, rightn, leftn} <= ~mouse.mouse_btn;
  end

  // busy reflects whether any steps are still pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= 1'b0;
    else       busy <= (acc_x != '0) || (acc_y != '0);
  end

  assign x_out = x_ph;
  assign y_out = y_ph;

endmodule
